// File: rtl/jpeg_rle_expander_pkg.sv
// Shared types and constants for the JPEG decoder-side run-length expander.
package jpeg_dec_pkg;

    localparam int unsigned COEF_W_DFLT = 12;
    localparam int unsigned SIZE_W_DFLT = 4;

    typedef enum logic [1:0] {
        S_DC,
        S_AC,
        S_ZERO,
        S_FLUSH
    } state_t;

    localparam logic [3:0] RUN_ZRL  = 4'd15;
    localparam logic [5:0] BLK_LAST = 6'd63;

endpackage

// File: rtl/jpeg_rle_expander_if.sv
// Symbol input bus (from the Huffman decoder) and coefficient output bus.
interface jpeg_sym_if import jpeg_dec_pkg::*; #(
    parameter int unsigned COEF_W = COEF_W_DFLT,
    parameter int unsigned SIZE_W = SIZE_W_DFLT
);
    logic              sym_valid;
    logic              sym_ready;
    logic              sym_dc;
    logic [3:0]        sym_run;
    logic [SIZE_W-1:0] sym_size;
    logic [COEF_W-1:0] sym_amp;

    modport master (output sym_valid, sym_dc, sym_run, sym_size, sym_amp, input sym_ready);
    modport slave  (input sym_valid, sym_dc, sym_run, sym_size, sym_amp, output sym_ready);
endinterface

interface jpeg_coef_if import jpeg_dec_pkg::*; #(
    parameter int unsigned COEF_W = COEF_W_DFLT
);
    logic              coef_valid;
    logic              coef_ready;
    logic [COEF_W-1:0] coef;
    logic [5:0]        coef_idx;
    logic              coef_last;

    modport master (output coef_valid, coef, coef_idx, coef_last, input coef_ready);
    modport slave  (input coef_valid, coef, coef_idx, coef_last, output coef_ready);
endinterface

// File: rtl/jpeg_rle_expander_vli_decode.sv
// Combinational JPEG VLI decode: (size, raw amplitude bits) -> signed value.
module jpeg_vli_decode import jpeg_dec_pkg::*; #(
    parameter int unsigned COEF_W = COEF_W_DFLT,
    parameter int unsigned SIZE_W = SIZE_W_DFLT
) (
    input  logic [SIZE_W-1:0] i_size,
    input  logic [COEF_W-1:0] i_amp,
    output logic [COEF_W-1:0] o_val,
    output logic              o_ovf
);
    logic [COEF_W-1:0] w_mask;
    logic              w_msb;

    always_comb begin
        w_mask = '0;
        w_msb  = 1'b0;
        o_val  = '0;
        o_ovf  = 1'b0;
        for (int unsigned b = 0; b < COEF_W; b++) begin
            w_mask[b] = (b < 32'(i_size));
            if (b + 1 == 32'(i_size)) w_msb = i_amp[b];
        end
        // Leading 0 marks a negative code: value = amp - (2^size - 1).
        if (32'(i_size) > COEF_W) begin
            o_ovf = 1'b1;
        end else if (i_size != '0) begin
            o_val = w_msb ? (i_amp & w_mask) : ((i_amp & w_mask) - w_mask);
        end
    end

endmodule

// File: rtl/jpeg_rle_expander.sv
// Expands (run, size, amplitude) symbols into the 64 zig-zag coefficients of
// an 8x8 block, one per cycle, with DC prediction, ZRL and EOB handling.
module jpeg_rle_expander import jpeg_dec_pkg::*; #(
    parameter int unsigned COEF_W = COEF_W_DFLT,
    parameter int unsigned SIZE_W = SIZE_W_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    jpeg_sym_if.slave   sym,
    jpeg_coef_if.master coef_bus,
    output logic        err
);
    state_t            r_state, w_state_nxt;
    logic [5:0]        r_idx, w_idx_nxt;
    logic [COEF_W-1:0] r_dc_pred, w_dc_pred_nxt;
    logic [COEF_W-1:0] r_pend_val, w_pend_val_nxt;
    logic [3:0]        r_zcnt, w_zcnt_nxt;
    logic              r_pend_valid, w_pend_valid_nxt;
    logic              r_dc_hold, w_dc_hold_nxt;
    logic              r_err, w_err_nxt;

    logic              r_coef_valid;
    logic [COEF_W-1:0] r_coef;
    logic [5:0]        r_coef_idx;
    logic              r_coef_last;

    logic              w_out_free, w_sym_ready, w_acc, w_emit;
    logic [COEF_W-1:0] w_emit_val, w_vli_val, w_dc_add, w_dc_sum;
    logic              w_vli_ovf, w_is_eob, w_is_zrl, w_overrun;
    logic [3:0]        w_run_eff;
    logic [6:0]        w_span;

    jpeg_vli_decode #(.COEF_W(COEF_W), .SIZE_W(SIZE_W)) u_vli (
        .i_size (sym.sym_size),
        .i_amp  (sym.sym_amp),
        .o_val  (w_vli_val),
        .o_ovf  (w_vli_ovf)
    );

    assign w_out_free  = !r_coef_valid || coef_bus.coef_ready;
    assign w_sym_ready = rst_n && !frame_start && w_out_free && !r_dc_hold &&
                         (r_state == S_DC || r_state == S_AC);
    assign w_acc       = sym.sym_valid && w_sym_ready;
    assign w_is_eob    = (sym.sym_run == 4'd0) && (sym.sym_size == '0);
    assign w_is_zrl    = (sym.sym_run == RUN_ZRL) && (sym.sym_size == '0);
    assign w_run_eff   = w_is_zrl ? RUN_ZRL : sym.sym_run;
    assign w_span      = {1'b0, r_idx} + {3'b000, w_run_eff};
    assign w_overrun   = (w_span > 7'd63);
    // A DC symbol held over from an interrupted block feeds the predictor directly.
    assign w_dc_add    = r_dc_hold ? r_pend_val : w_vli_val;
    assign w_dc_sum    = r_dc_pred + w_dc_add;

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_dc_pred_nxt    = r_dc_pred;
        w_pend_val_nxt   = r_pend_val;
        w_zcnt_nxt       = r_zcnt;
        w_pend_valid_nxt = r_pend_valid;
        w_dc_hold_nxt    = r_dc_hold;
        w_err_nxt        = r_err;
        w_emit           = 1'b0;
        w_emit_val       = '0;
        if (w_acc && w_vli_ovf) w_err_nxt = 1'b1;
        case (r_state)
            S_DC: begin
                if (r_dc_hold && w_out_free) begin
                    w_emit        = 1'b1;
                    w_emit_val    = w_dc_sum;
                    w_dc_pred_nxt = w_dc_sum;
                    w_dc_hold_nxt = 1'b0;
                    w_state_nxt   = S_AC;
                end else if (w_acc) begin
                    if (sym.sym_dc) begin
                        w_emit        = 1'b1;
                        w_emit_val    = w_dc_sum;
                        w_dc_pred_nxt = w_dc_sum;
                        w_state_nxt   = S_AC;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_AC: begin
                if (w_acc) begin
                    w_emit = 1'b1;
                    if (sym.sym_dc) begin
                        w_err_nxt      = 1'b1;
                        w_dc_hold_nxt  = 1'b1;
                        w_pend_val_nxt = w_vli_val;
                        w_state_nxt    = S_FLUSH;
                    end else if (w_is_eob) begin
                        w_state_nxt = S_FLUSH;
                    end else if (w_overrun) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_FLUSH;
                    end else if (w_is_zrl) begin
                        w_zcnt_nxt       = RUN_ZRL;
                        w_pend_valid_nxt = 1'b0;
                        w_state_nxt      = S_ZERO;
                    end else if (sym.sym_run == 4'd0) begin
                        w_emit_val = w_vli_val;
                    end else begin
                        w_zcnt_nxt       = sym.sym_run - 4'd1;
                        w_pend_valid_nxt = 1'b1;
                        w_pend_val_nxt   = w_vli_val;
                        w_state_nxt      = S_ZERO;
                    end
                end
            end
            S_ZERO: begin
                if (w_out_free) begin
                    w_emit = 1'b1;
                    if (r_zcnt != 4'd0) begin
                        w_zcnt_nxt = r_zcnt - 4'd1;
                        if (r_zcnt == 4'd1 && !r_pend_valid) w_state_nxt = S_AC;
                    end else begin
                        w_emit_val       = r_pend_val;
                        w_pend_valid_nxt = 1'b0;
                        w_state_nxt      = S_AC;
                    end
                end
            end
            S_FLUSH: begin
                if (w_out_free) w_emit = 1'b1;
            end
            default: w_state_nxt = S_DC;
        endcase
        if (w_emit) begin
            w_idx_nxt = r_idx + 6'd1;
            if (r_idx == BLK_LAST) begin
                w_idx_nxt        = '0;
                w_state_nxt      = S_DC;
                w_pend_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_DC;
            r_idx        <= '0;
            r_dc_pred    <= '0;
            r_pend_val   <= '0;
            r_zcnt       <= '0;
            r_pend_valid <= 1'b0;
            r_dc_hold    <= 1'b0;
            r_err        <= 1'b0;
            r_coef_valid <= 1'b0;
            r_coef       <= '0;
            r_coef_idx   <= '0;
            r_coef_last  <= 1'b0;
        end else if (frame_start) begin
            r_state      <= S_DC;
            r_idx        <= '0;
            r_dc_pred    <= '0;
            r_zcnt       <= '0;
            r_pend_valid <= 1'b0;
            r_dc_hold    <= 1'b0;
            r_err        <= 1'b0;
            r_coef_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_dc_pred    <= w_dc_pred_nxt;
            r_pend_val   <= w_pend_val_nxt;
            r_zcnt       <= w_zcnt_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_dc_hold    <= w_dc_hold_nxt;
            r_err        <= w_err_nxt;
            if (w_emit) begin
                r_coef_valid <= 1'b1;
                r_coef       <= w_emit_val;
                r_coef_idx   <= r_idx;
                r_coef_last  <= (r_idx == BLK_LAST);
            end else if (coef_bus.coef_ready) begin
                r_coef_valid <= 1'b0;
            end
        end
    end

    assign sym.sym_ready       = w_sym_ready;
    assign coef_bus.coef_valid = r_coef_valid;
    assign coef_bus.coef       = r_coef;
    assign coef_bus.coef_idx   = r_coef_idx;
    assign coef_bus.coef_last  = r_coef_last;
    assign err                 = r_err;

endmodule

// File: doc/jpeg_rle_expander.md
Name: jpeg_rle_expander

Overview:
Decoder-side counterpart of the JPEG entropy-coding path. It takes Huffman-decoded (run, size, amplitude) symbols and expands them into the 64 quantized coefficients of an 8x8 block, in zig-zag order, one coefficient per cycle. It also reconstructs DC from the coded difference using a running predictor, and handles the ZRL and EOB codes. It sits between the Huffman symbol decoder and the dequantizer/zig-zag reorder buffer.

Parameters:
COEF_W, 12, signed coefficient width; also the maximum VLI size supported.
SIZE_W, 4, width of the size (category) field.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  single-cycle pulse; clears the DC predictor and block state
sym_valid  in  1  symbol valid
sym_ready  out  1  symbol accept
sym_dc  in  1  1 = DC symbol (run is ignored); 0 = AC symbol
sym_run  in  4  AC zero-run length
sym_size  in  SIZE_W  VLI category; 0 means a zero-value code
sym_amp  in  COEF_W  raw VLI bits, right-aligned
coef_valid  out  1  output coefficient valid
coef_ready  in  1  downstream accept
coef  out  COEF_W  signed coefficient
coef_idx  out  6  zig-zag index, 0..63
coef_last  out  1  asserted with coef_idx == 63
err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): state=S_DC, idx=0, dc_pred=0, coef_valid=0, coef=0, coef_idx=0, coef_last=0, err=0. sym_ready is low while in reset.
- Handshakes: a transfer occurs when valid&ready on the same edge. Output registers hold stable while coef_valid=1 and coef_ready=0.
- sym_ready=1 only in S_DC or S_AC, when the output register is empty or being drained in the same cycle.
- VLI decode, val(size, amp):
  - size=0 gives 0.
  - If amp[size-1]=1, the value is +amp (low size bits).
  - Otherwise the value is amp - (2^size - 1).
  - size > COEF_W sets err; the value is then treated as 0.
- States:
  - S_DC: accepts a symbol with sym_dc=1. dc_pred <= dc_pred + val, wrapping modulo 2^COEF_W. Emits coef=new dc_pred at idx 0, then goes to S_AC. An AC symbol arriving here sets err and is consumed without output.
  - S_AC, symbol with run=0 and size=0 (EOB): go to S_FLUSH.
  - S_AC, symbol with run=15 and size=0 (ZRL): zcnt <= 16, go to S_ZERO with no value pending.
  - S_AC, other symbols: zcnt <= run, value pending = val, go to S_ZERO. If run=0, the value is emitted directly.
  - S_AC, symbol with sym_dc=1: sets err; the block is flushed with zeros and the symbol is then processed as DC of the next block.
  - S_ZERO: emits a 0 per accepted output until zcnt=0, then emits the pending value if any, then returns to S_AC.
  - S_FLUSH: emits zeros through idx 63.
- Index handling:
  - idx increments on every output transfer.
  - An output with idx=63 asserts coef_last. After that transfer: idx <= 0, state <= S_DC.
  - If a run or ZRL would pass idx 63, set err, emit zeros through 63, drop the pending value, and end the block.
  - A non-EOB symbol whose value lands exactly on idx 63 ends the block with no EOB expected.
- Latency: a symbol accepted at edge T produces its first output (zero or value) with coef_valid=1 after edge T. Throughput is 1 coefficient/cycle with coef_ready held high.
- frame_start:
  - Takes priority over all other events in its cycle.
  - Clears dc_pred, idx and err.
  - Drops any in-flight output and sets state=S_DC.
  - A symbol presented in the same cycle is not accepted; sym_ready is forced 0 that cycle.
- err clears only on reset or frame_start.

Decomposition:
- Shared package jpeg_dec_pkg holds:
  - COEF_W and SIZE_W defaults
  - state enum {S_DC, S_AC, S_ZERO, S_FLUSH}
  - constants RUN_ZRL=15, BLK_LAST=63
- One natural sub-module: jpeg_vli_decode. It is purely combinational: (size, amp) -> signed value plus size-overflow flag. It is shared with the DC path.

Test Plan:
- DC only then EOB: dc size=3 amp=5, then AC EOB -> coef 5 at idx0, 63 zeros, coef_last at idx63, err=0.
- Negative VLI and predictor: block1 DC size=3 amp=2 (-5), EOB; block2 DC size=3 amp=5 (+5), EOB -> idx0 coef -5, then 0.
- Runs and ZRL: DC size=0, AC(run=2,size=1,amp=1), ZRL, AC(run=0,size=2,amp=0), EOB -> idx3=+1, idx20=-3, all others 0.
- Overflow: DC then 4 ZRLs (64 zeros) -> err=1, zeros through idx63, last asserted once, next DC accepted normally.
- Backpressure: coef_ready toggled 1,0,0,1 random -> coef/coef_idx stable while stalled; 64 outputs per block; no symbol lost.
- Mid-block frame_start with coef_valid stalled -> next output is a new DC at idx0 with predictor 0, err=0.
